display_scan_controller: RTL
============================

# display_scan_controller

Sequences the HUB75-style panel datapath. The block walks the framebuffer column by column and drives the `cycle` value consumed by `display_color_encoder`. It also generates panel shift-clock, latch, output-enable and row-address signals, so that each pixel of value v is lit for exactly v of the 2^cyclewidth − 1 PWM subframes per row. It sits between the framebuffer (synchronous read, 1-cycle latency) and the encoder/panel pins.

## Interface
Parameters:
- `cyclewidth`, 8: PWM depth; must match the encoder's `cyclewidth`.
- `colbits`, 6: column address width; columns = 2^colbits.
- `rowbits`, 4: row address width; rows = 2^rowbits.
- `ontime`, 16: OE-active cycles per subframe; must be ≥ 1.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run frames. Sampled only in IDLE and at the frame boundary.
- `pixel_row` out rowbits: framebuffer read row.
- `pixel_col` out colbits: framebuffer read column.
- `cycle` out cyclewidth: PWM compare value to the encoder.
- `display_clk` out 1: panel shift clock.
- `display_latch` out 1: panel latch strobe.
- `display_oe` out 1: panel output enable, active low (1 = blank).
- `display_row` out rowbits: panel row address.
- `frame_done` out 1: one-cycle pulse after the last subframe of the last row.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE
  - `pixel_row` 0, `pixel_col` 0, `display_row` 0
  - `cycle` 1
  - `display_clk` 0, `display_latch` 0, `frame_done` 0
  - `display_oe` 1
- IDLE: `display_oe`=1. If `enable`=1, go to SHIFT next cycle with `pixel_col`=0.
- SHIFT: 2·columns cycles.
  - `pixel_col` = k for local cycles 2k and 2k+1.
  - `display_clk`=1 in local cycle 2k+3 for k = 0..columns−1, and 0 otherwise. The pulses for k ≥ columns−1 fall in DRAIN.
  - The `display_clk` pipeline runs continuously across the SHIFT→DRAIN boundary.
- DRAIN: 2 cycles. Completes the last column's clock pulse. `pixel_col` is held at columns−1.
- BLANK: 1 cycle. `display_oe`=1.
- LATCH: 1 cycle.
  - `display_latch`=1, `display_oe`=1.
  - `display_row` ← `pixel_row` on this cycle.
- DISPLAY: `ontime` cycles, `display_oe`=0. On the last cycle, advance the counters:
  - `cycle` increments. If `cycle` = 2^cyclewidth − 1, `cycle` ← 1 and `pixel_row` increments (wraps at rows).
  - If `pixel_row` wraps to 0 at the same time: pulse `frame_done`, then go to IDLE if `enable`=0, otherwise SHIFT.
  - Otherwise go to SHIFT.
- `cycle` is never 0, and is constant from the first SHIFT cycle through the end of DISPLAY. This guarantees the encoder output for every shifted column uses a single compare value.
- `display_oe` is 1 in every state except DISPLAY. Overlapping latch and OE-active is forbidden.
- `rst` asserted in any state, including mid-SHIFT: all outputs take their reset values on the next edge. No partial-row completion.
- `enable` deasserted mid-frame: ignored until the frame boundary.

## Timing
- Read pipeline:
  - Address at cycle n → framebuffer data at n+1 → encoder `rgb` at n+2.
  - `rgb` for column k is stable in local cycles 2k+2 and 2k+3.
  - The panel samples on the `display_clk` rising edge at the start of 2k+3, one full cycle after data is stable.
- Subframe length: 2·columns + 2 + 1 + 1 + `ontime` cycles. With defaults: 128+2+1+1+16 = 148.
- Row length: (2^cyclewidth − 1) subframes. Frame length: rows × row length.
- Exactly `columns` `display_clk` pulses per subframe, each 1 cycle high with ≥ 1 cycle low between.
- `frame_done` is high for the single cycle following the final DISPLAY cycle of the frame.

## Test plan
- Reset: hold `rst` 3 cycles, `enable`=0 → all outputs at reset values; stays IDLE for 100 cycles with `display_oe`=1.
- Single subframe with `colbits`=2, `ontime`=4, `enable`=1:
  - `pixel_col` sequence 0,0,1,1,2,2,3,3,3,3.
  - `display_clk` high exactly at local cycles 3,5,7,9.
  - `display_latch` high at cycle 11, `display_oe`=0 for cycles 12–15.
  - Next SHIFT starts at cycle 16 with `cycle`=2.
- Sweep with `cyclewidth`=3, `rowbits`=1:
  - `cycle` runs 1..7, then returns to 1 with `pixel_row` 0→1.
  - `display_row` changes only in LATCH.
  - `frame_done` pulses once after row 1's 7th subframe.
- Enable control: drop `enable` mid-frame → frame completes, `frame_done` pulses, block enters IDLE. Re-raise → restarts at row 0, `cycle` 1.
- Reset mid-SHIFT at column 5 → next cycle all outputs at reset values, no further `display_clk` pulses.
- End-to-end with framebuffer model and `display_color_encoder` (`cyclewidth`=3): pixel values 0, 3, 7 → the sampled lit bit is 1 in exactly 0, 3 and 7 of the 7 subframes respectively.

Source files
------------

// File: rtl/display_scan_controller.sv
// ---------------------------------------------------------------------------
// display_scan_controller
//
// Purpose:
//   Sequences the HUB75-style panel datapath. For each PWM subframe of a row
//   it walks the framebuffer column by column (two cycles per column), emits
//   one panel shift-clock pulse per column, blanks, latches the shifted row,
//   then enables the panel outputs for `ontime` cycles. The PWM compare value
//   `cycle` steps 1 .. 2^cyclewidth-1 per row, so a pixel of value v is lit
//   in exactly v subframes of its row.
//
// Ports:
//   clk           in   sole clock
//   rst           in   synchronous, active-high reset
//   enable        in   run frames; sampled only in IDLE and at frame boundary
//   pixel_row     out  framebuffer read row
//   pixel_col     out  framebuffer read column
//   cycle         out  PWM compare value to the colour encoder (never 0)
//   display_clk   out  panel shift clock
//   display_latch out  panel latch strobe
//   display_oe    out  panel output enable, active low (1 = blank)
//   display_row   out  panel row address
//   frame_done    out  one-cycle pulse after the last subframe of a frame
//
// All outputs come straight from flops: the combinational block works out
// the next state and counters, and the output values are derived from those
// next values so that they line up with the state they belong to.
// ---------------------------------------------------------------------------
module display_scan_controller #(
    parameter int cyclewidth = 8,
    parameter int colbits    = 6,
    parameter int rowbits    = 4,
    parameter int ontime     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic [rowbits-1:0]    pixel_row,
    output logic [colbits-1:0]    pixel_col,
    output logic [cyclewidth-1:0] cycle,
    output logic                  display_clk,
    output logic                  display_latch,
    output logic                  display_oe,
    output logic [rowbits-1:0]    display_row,
    output logic                  frame_done
);

    localparam int COLS = 1 << colbits;

    // The shift/drain phase counts local cycles 0 .. 2*COLS+1, so two more
    // bits than the column address are needed.
    localparam int SW = colbits + 2;
    localparam logic [SW-1:0] SHIFT_LAST = SW'(2 * COLS - 1);
    localparam logic [SW-1:0] DRAIN_LAST = SW'(2 * COLS + 1);
    localparam logic [SW-1:0] SHIFT_ONE  = SW'(1);
    localparam logic [SW-1:0] FIRST_CLK  = SW'(3);

    localparam int OW = (ontime > 1) ? $clog2(ontime) : 1;
    localparam logic [OW-1:0] ON_LAST = OW'(ontime - 1);
    localparam logic [OW-1:0] ON_ONE  = OW'(1);

    localparam logic [cyclewidth-1:0] CYCLE_MAX = '1;
    localparam logic [cyclewidth-1:0] CYCLE_ONE = cyclewidth'(1);
    localparam logic [rowbits-1:0]    ROW_MAX   = '1;
    localparam logic [rowbits-1:0]    ROW_ONE   = rowbits'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DRAIN,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } state_e;

    state_e                  state_q,        state_d;
    logic [SW-1:0]           shiftCnt_q,     shiftCnt_d;
    logic [OW-1:0]           onCnt_q,        onCnt_d;
    logic [cyclewidth-1:0]   cycle_q,        cycle_d;
    logic [rowbits-1:0]      pixelRow_q,     pixelRow_d;
    logic [colbits-1:0]      pixelCol_q,     pixelCol_d;
    logic                    displayClk_q,   displayClk_d;
    logic                    displayLatch_q, displayLatch_d;
    logic                    displayOe_q,    displayOe_d;
    logic [rowbits-1:0]      displayRow_q,   displayRow_d;
    logic                    frameDone_q,    frameDone_d;

    // Next-state logic. The shift counter keeps running from SHIFT into
    // DRAIN so the shift-clock pattern continues unbroken across the
    // boundary. The PWM value and row only move on the final DISPLAY cycle,
    // which keeps `cycle` constant for everything shifted into that subframe.
    // `enable` is looked at only in IDLE and when the last row wraps.
    always_comb begin
        state_d     = state_q;
        shiftCnt_d  = shiftCnt_q;
        onCnt_d     = onCnt_q;
        cycle_d     = cycle_q;
        pixelRow_d  = pixelRow_q;
        frameDone_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_SHIFT;
                    shiftCnt_d = '0;
                end
            end

            ST_SHIFT: begin
                shiftCnt_d = shiftCnt_q + SHIFT_ONE;
                if (shiftCnt_q == SHIFT_LAST) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                shiftCnt_d = shiftCnt_q + SHIFT_ONE;
                if (shiftCnt_q == DRAIN_LAST) begin
                    state_d = ST_BLANK;
                end
            end

            ST_BLANK: begin
                state_d = ST_LATCH;
            end

            ST_LATCH: begin
                state_d = ST_DISPLAY;
                onCnt_d = '0;
            end

            ST_DISPLAY: begin
                onCnt_d = onCnt_q + ON_ONE;
                if (onCnt_q == ON_LAST) begin
                    state_d    = ST_SHIFT;
                    shiftCnt_d = '0;
                    if (cycle_q == CYCLE_MAX) begin
                        cycle_d    = CYCLE_ONE;
                        pixelRow_d = pixelRow_q + ROW_ONE;
                        if (pixelRow_q == ROW_MAX) begin
                            frameDone_d = 1'b1;
                            if (!enable) begin
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        cycle_d = cycle_q + CYCLE_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state and
    // next counters. Column k is addressed for local cycles 2k and 2k+1; the
    // column address is held through DRAIN and beyond. The shift clock is
    // high on odd local cycles from 3 up to 2*COLS+1, which gives one pulse
    // per column, each one cycle after that column's encoder data settles.
    always_comb begin
        pixelCol_d     = pixelCol_q;
        displayClk_d   = 1'b0;
        displayLatch_d = 1'b0;
        displayOe_d    = 1'b1;
        displayRow_d   = displayRow_q;

        if (state_d == ST_SHIFT) begin
            pixelCol_d = shiftCnt_d[colbits:1];
        end

        if ((state_d == ST_SHIFT) || (state_d == ST_DRAIN)) begin
            displayClk_d = shiftCnt_d[0] && (shiftCnt_d >= FIRST_CLK);
        end

        if (state_d == ST_LATCH) begin
            displayLatch_d = 1'b1;
            displayRow_d   = pixelRow_d;
        end

        // Outputs are enabled only while displaying, never during the latch.
        if (state_d == ST_DISPLAY) begin
            displayOe_d = 1'b0;
        end
    end

    // State and output registers. Reset abandons any partially shifted row
    // immediately and returns everything to the idle, blanked condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            shiftCnt_q     <= '0;
            onCnt_q        <= '0;
            cycle_q        <= CYCLE_ONE;
            pixelRow_q     <= '0;
            pixelCol_q     <= '0;
            displayClk_q   <= 1'b0;
            displayLatch_q <= 1'b0;
            displayOe_q    <= 1'b1;
            displayRow_q   <= '0;
            frameDone_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            shiftCnt_q     <= shiftCnt_d;
            onCnt_q        <= onCnt_d;
            cycle_q        <= cycle_d;
            pixelRow_q     <= pixelRow_d;
            pixelCol_q     <= pixelCol_d;
            displayClk_q   <= displayClk_d;
            displayLatch_q <= displayLatch_d;
            displayOe_q    <= displayOe_d;
            displayRow_q   <= displayRow_d;
            frameDone_q    <= frameDone_d;
        end
    end

    assign pixel_row     = pixelRow_q;
    assign pixel_col     = pixelCol_q;
    assign cycle         = cycle_q;
    assign display_clk   = displayClk_q;
    assign display_latch = displayLatch_q;
    assign display_oe    = displayOe_q;
    assign display_row   = displayRow_q;
    assign frame_done    = frameDone_q;

endmodule
